// File: rtl/ts_cc_monitor.sv
// Multi-PID MPEG-2 TS continuity-counter monitor: parses the TS header and the
// adaptation-field flag byte, tracks CC per PID and counts discontinuities.
module ts_cc_monitor #(
  parameter int NUM_PIDS    = 8,
  parameter int COUNT_WIDTH = 8,
  parameter int IDX_W       = $clog2(NUM_PIDS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   valid,
  input  logic                   sync,
  input  logic [7:0]             ts_data,
  input  logic                   en_reset_counter,
  output logic [COUNT_WIDTH-1:0] error_count,
  output logic                   error_pulse,
  output logic                   table_full,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic                   rd_valid,
  output logic [12:0]            rd_pid,
  output logic [COUNT_WIDTH-1:0] rd_count
);

  localparam logic [7:0]             LAST_IDX = 8'd188;
  localparam logic [12:0]            NULL_PID = 13'h1FFF;
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);

  // header parse state
  logic [7:0]  r_idx;
  logic        r_tei;
  logic [12:0] r_pid;
  logic [1:0]  r_afc;
  logic [3:0]  r_cc;
  logic        r_af_nz;
  logic        w_skip;

  // stage-1 evaluation register
  logic        r_s1_valid;
  logic [12:0] r_s1_pid;
  logic [3:0]  r_s1_cc;
  logic        r_s1_pay;
  logic        r_s1_di;

  // PID table
  logic [NUM_PIDS-1:0]    r_tv;
  logic [NUM_PIDS-1:0]    r_tdup;
  logic [12:0]            r_tpid [NUM_PIDS];
  logic [3:0]             r_tcc  [NUM_PIDS];
  logic [COUNT_WIDTH-1:0] r_tcnt [NUM_PIDS];

  logic [COUNT_WIDTH-1:0] r_error_count;
  logic                   r_error_pulse;
  logic                   r_table_full;

  logic             w_hit;
  logic [IDX_W-1:0] w_hit_idx;
  logic             w_free_found;
  logic [IDX_W-1:0] w_free_idx;
  logic             w_err;
  logic             w_dup_nx;
  logic [3:0]       w_last;

  assign w_skip = r_tei | (r_pid == NULL_PID) | (r_afc == 2'b00);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx      <= '0;
      r_tei      <= 1'b0;
      r_pid      <= '0;
      r_afc      <= '0;
      r_cc       <= '0;
      r_af_nz    <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_pid   <= '0;
      r_s1_cc    <= '0;
      r_s1_pay   <= 1'b0;
      r_s1_di    <= 1'b0;
    end else begin
      r_s1_valid <= 1'b0;
      if (valid) begin
        if (sync) begin
          r_idx <= 8'd1;
        end else if (r_idx != 8'd0 && r_idx != LAST_IDX) begin
          r_idx <= r_idx + 8'd1;
          case (r_idx)
            8'd1: begin
              r_tei       <= ts_data[7];
              r_pid[12:8] <= ts_data[4:0];
            end
            8'd2: r_pid[7:0] <= ts_data;
            8'd3: begin
              r_afc <= ts_data[5:4];
              r_cc  <= ts_data[3:0];
            end
            8'd4: r_af_nz <= |ts_data;
            8'd5: begin
              // DI is only meaningful when an adaptation field of nonzero length exists
              r_s1_valid <= ~w_skip;
              r_s1_pid   <= r_pid;
              r_s1_cc    <= r_cc;
              r_s1_pay   <= r_afc[0];
              r_s1_di    <= r_afc[1] & r_af_nz & ts_data[7];
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    w_hit        = 1'b0;
    w_hit_idx    = '0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int unsigned i = 0; i < NUM_PIDS; i++) begin
      if (r_tv[i] && r_tpid[i] == r_s1_pid && !w_hit) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
      if (!r_tv[i] && !w_free_found) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
    end

    w_last   = r_tcc[w_hit_idx];
    w_dup_nx = r_tdup[w_hit_idx];
    w_err    = 1'b0;
    if (r_s1_valid && w_hit) begin
      if (r_s1_di) begin
        w_dup_nx = 1'b0;
      end else if (!r_s1_pay) begin
        w_err = (r_s1_cc != w_last);
      end else if (r_s1_cc == w_last) begin
        if (r_tdup[w_hit_idx]) w_err    = 1'b1;
        else                   w_dup_nx = 1'b1;
      end else if (r_s1_cc == w_last + 4'd1) begin
        w_dup_nx = 1'b0;
      end else begin
        w_err    = 1'b1;
        w_dup_nx = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tv          <= '0;
      r_tdup        <= '0;
      r_error_count <= '0;
      r_error_pulse <= 1'b0;
      r_table_full  <= 1'b0;
      for (int unsigned i = 0; i < NUM_PIDS; i++) begin
        r_tpid[i] <= '0;
        r_tcc[i]  <= '0;
        r_tcnt[i] <= '0;
      end
    end else begin
      r_error_pulse <= w_err;
      if (r_s1_valid) begin
        if (w_hit) begin
          r_tcc[w_hit_idx]  <= r_s1_cc;
          r_tdup[w_hit_idx] <= w_dup_nx;
        end else if (w_free_found) begin
          r_tv[w_free_idx]   <= 1'b1;
          r_tpid[w_free_idx] <= r_s1_pid;
          r_tcc[w_free_idx]  <= r_s1_cc;
          r_tdup[w_free_idx] <= 1'b0;
        end
      end
      // counter clear overrides any increment or table_full set in the same cycle
      if (en_reset_counter) begin
        r_error_count <= '0;
        r_table_full  <= 1'b0;
        for (int unsigned i = 0; i < NUM_PIDS; i++) r_tcnt[i] <= '0;
      end else begin
        if (r_s1_valid && !w_hit && !w_free_found) r_table_full <= 1'b1;
        if (w_err) begin
          if (r_error_count != CNT_MAX) r_error_count <= r_error_count + CNT_ONE;
          if (r_tcnt[w_hit_idx] != CNT_MAX)
            r_tcnt[w_hit_idx] <= r_tcnt[w_hit_idx] + CNT_ONE;
        end
      end
    end
  end

  assign error_count = r_error_count;
  assign error_pulse = r_error_pulse;
  assign table_full  = r_table_full;
  assign rd_valid    = r_tv[rd_idx];
  assign rd_pid      = r_tv[rd_idx] ? r_tpid[rd_idx] : '0;
  assign rd_count    = r_tv[rd_idx] ? r_tcnt[rd_idx] : '0;

endmodule

// File: doc/ts_cc_monitor.md
Name: ts_cc_monitor

Overview:
Multi-PID continuity-counter monitor for the MPEG-2 TS byte stream; generalises the single-counter packet loss counter to a parametrised table of tracked PIDs. Parses the 4-byte TS header plus the first adaptation-field flag byte, applies ISO 13818-1 CC rules (duplicates, no-payload packets, discontinuity_indicator), and keeps saturating per-PID and total discontinuity counters. Sits beside the sync detector on the 8-bit TS bus, read by the QoS control block.

Parameters:
NUM_PIDS, 8, number of PID table entries (power of 2, >=2)
COUNT_WIDTH, 8, width of every error counter (saturating)
IDX_W, $clog2(NUM_PIDS), width of table read index

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
valid  input  1  ts_data/sync qualifier; bytes accepted only when high
sync  input  1  high with valid on byte 0 (0x47) of each packet
ts_data  input  8  TS byte stream
en_reset_counter  input  1  synchronous clear of all counters and table_full; PID table contents kept
error_count  output  COUNT_WIDTH  total CC discontinuity events, saturating
error_pulse  output  1  one-cycle strobe per detected discontinuity
table_full  output  1  sticky: a new PID arrived with no free entry
rd_idx  input  IDX_W  table entry select
rd_valid  output  1  entry rd_idx allocated
rd_pid  output  13  PID of entry rd_idx
rd_count  output  COUNT_WIDTH  discontinuity count of entry rd_idx

Behaviour:
- Reset (async, reset_n=0): error_count=0, error_pulse=0, table_full=0, all entries invalid, rd_* = 0, byte index idle.
- Byte index: valid&sync loads index 1 (byte 0 consumed); each further valid byte increments; index held while valid=0. valid&sync at any index aborts current packet (no evaluation) and restarts. Index saturates at 188; bytes after 188 without sync ignored.
- Header capture: byte1 TEI=bit7, PID[12:8]=bits4:0; byte2 PID[7:0]; byte3 AFC=bits5:4, CC=bits3:0; byte4 AF length; byte5 bit7 = discontinuity_indicator (DI), used only if AFC[1]=1 and AF length>0, else DI=0.
- Evaluation point: acceptance of byte 5 (sampled at edge N). If AFC[1]=0, byte 4/5 values ignored but evaluation still at byte 5. Packets shorter than 6 bytes are never evaluated.
- Skipped packets: TEI=1, PID=0x1FFF, or AFC=00 -> no table access, no count.
- Edge N+1 (stage 2, one-cycle pipeline): CAM match of PID against valid entries.
  - No match, free entry: allocate lowest free index, store PID, last_cc=CC, dup=0; no error.
  - No match, table full: set table_full; no count.
  - Match, DI=1: last_cc=CC, dup=0, no error.
  - Match, AFC[0]=0 (no payload): expected=last_cc; CC!=expected -> error.
  - Match, payload: CC==last_cc and dup=0 -> duplicate accepted, dup=1; CC==last_cc and dup=1 -> error; CC==(last_cc+1) mod 16 -> ok, dup=0; else error, dup=0.
  - last_cc always updated to CC on match.
  - Error: error_pulse=1 for that cycle; entry count and error_count +1, each saturating at 2^COUNT_WIDTH-1.
- Same-cycle conflict: en_reset_counter wins; counters clear, pending error increment dropped, error_pulse still asserted, table update still applied.
- rd_* combinational from table registers; rd_pid/rd_count read 0 when entry invalid.
- Allocation is permanent until reset_n; no eviction.

Test Plan:
- Single PID 0x100, 50 packets CC 0..15 wrapping, AFC=01 -> error_count=0, error_pulse never high, rd_idx=0 gives rd_valid=1, rd_pid=0x100.
- PID 0x100 CC sequence 3,4,6,7 -> one error_pulse two cycles after byte 5 of CC=6 packet; error_count=1, rd_count[0]=1.
- PID 0x200 CC 5,5,6 -> no error (single duplicate); CC 5,5,5 -> error_count=1; AFC=10 packet with CC unchanged -> no error; DI=1 packet with CC jump 2->9 -> no error.
- NUM_PIDS=8, 9 distinct PIDs, then null PID 0x1FFF and TEI=1 packets with random CC -> table_full=1, entry 8's PID unused, nulls/TEI uncounted.
- 300 consecutive CC errors on one PID -> error_count and rd_count hold at 255; pulse en_reset_counter -> both 0, table_full 0, rd_valid still 1; next in-order packet no error.
- sync reasserted at byte 3 of packet (truncation), valid gaps of 1-5 cycles inside header, and reset_n asserted mid-packet -> truncated packet not evaluated, gaps do not shift parsing, all outputs 0 immediately on reset.
